// File: rtl/dpram_param.sv
// ---------------------------------------------------------------------------
// dpram_param
//   True-dual-port synchronous RAM used as FCPU program/data storage.
//   Port A is the CPU data port, port B the fetch/loader port.
//   Width, depth and same-port read-during-write behaviour are configurable.
//   Optional output register, per-port read-valid flags, cross-port
//   same-address collision arbitration and a post-reset clear sweep.
//
// Ports
//   clk          single clock for both ports
//   rst_n        asynchronous active-low reset
//   en_a/en_b    port access enable (ignored while busy)
//   we_a/we_b    port write enable, qualified by en_x
//   addr_a/b     port address
//   data_a/b     port write data
//   q_a/q_b      port read data (holds last value when no access completes)
//   q_valid_a/b  q_x carries the result of an accepted access this cycle
//   busy         clear sweep running; both ports ignore requests
//   coll         one-cycle pulse after a same-address cross-port conflict
// ---------------------------------------------------------------------------
module dpram_param #(
    parameter int                 DATA_W     = 8,
    parameter int                 ADDR_W     = 11,
    parameter int                 WRITE_MODE = 0,
    parameter int                 OUT_REG    = 0,
    parameter int                 CLEAR_EN   = 0,
    parameter logic [DATA_W-1:0]  CLEAR_VAL  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] q_a,
    output logic              q_valid_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] q_b,
    output logic              q_valid_b,
    output logic              busy,
    output logic              coll
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy_i;
    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;

    logic acc_a, acc_b, wr_a, wr_b, wr_b_eff, same_addr, coll_d;

    assign busy      = busy_i;
    assign acc_a     = en_a & ~busy_i;
    assign acc_b     = en_b & ~busy_i;
    assign wr_a      = acc_a & we_a;
    assign wr_b      = acc_b & we_b;
    assign same_addr = acc_a & acc_b & (addr_a == addr_b);
    // Port A wins a same-address double write.
    assign wr_b_eff  = wr_b & ~(same_addr & wr_a);
    assign coll_d    = same_addr & (wr_a | wr_b);

    // -----------------------------------------------------------------------
    // Clear sequencer
    // -----------------------------------------------------------------------
    generate
        if (CLEAR_EN != 0) begin : g_clear
            // state | meaning
            // ------+-------------------------------------------------
            // IDLE  | sweep done, normal port access
            // SWEEP | writing CLEAR_VAL to sweep_cnt, ports locked out
            typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

            state_t            state, state_nxt;
            logic [ADDR_W-1:0] sweep_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state     <= SWEEP;
                    sweep_cnt <= '0;
                end else begin
                    state <= state_nxt;
                    if (state == SWEEP)
                        sweep_cnt <= sweep_cnt + ADDR_W'(1);
                end
            end

            always_comb begin
                state_nxt = state;
                case (state)
                    SWEEP:   if (sweep_cnt == '1) state_nxt = IDLE;
                    default: state_nxt = IDLE;
                endcase
            end

            always_comb begin
                busy_i   = (state == SWEEP);
                sweep_we = (state == SWEEP);
            end

            assign sweep_addr = sweep_cnt;
        end else begin : g_no_clear
            assign busy_i     = 1'b0;
            assign sweep_we   = 1'b0;
            assign sweep_addr = '0;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Storage (never reset)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (sweep_we)
            mem[sweep_addr] <= CLEAR_VAL;
        if (wr_a)
            mem[addr_a] <= data_a;
        if (wr_b_eff)
            mem[addr_b] <= data_b;
    end

    // -----------------------------------------------------------------------
    // First read stage. Reads sample the array before this edge's writes,
    // so a cross-port reader naturally sees the old contents.
    // -----------------------------------------------------------------------
    logic              upd_a, upd_b;
    logic [DATA_W-1:0] d_a, d_b;

    always_comb begin
        upd_a = acc_a;
        d_a   = mem[addr_a];
        if (wr_a) begin
            if (WRITE_MODE == 0)
                d_a = data_a;
            else if (WRITE_MODE != 1)
                upd_a = 1'b0;
        end
    end

    always_comb begin
        upd_b = acc_b;
        d_b   = mem[addr_b];
        if (wr_b) begin
            if (WRITE_MODE == 0)
                // A dropped B write reports what actually landed in the word.
                d_b = (same_addr & wr_a) ? data_a : data_b;
            else if (WRITE_MODE != 1)
                upd_b = 1'b0;
        end
    end

    logic [DATA_W-1:0] q1_a, q1_b;
    logic              v1_a, v1_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_a <= '0;
            q1_b <= '0;
            v1_a <= 1'b0;
            v1_b <= 1'b0;
            coll <= 1'b0;
        end else begin
            v1_a <= upd_a;
            v1_b <= upd_b;
            if (upd_a) q1_a <= d_a;
            if (upd_b) q1_b <= d_b;
            coll <= coll_d;
        end
    end

    // -----------------------------------------------------------------------
    // Optional output register
    // -----------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] q2_a, q2_b;
            logic              v2_a, v2_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q2_a <= '0;
                    q2_b <= '0;
                    v2_a <= 1'b0;
                    v2_b <= 1'b0;
                end else begin
                    v2_a <= v1_a;
                    v2_b <= v1_b;
                    if (v1_a) q2_a <= q1_a;
                    if (v1_b) q2_b <= q1_b;
                end
            end

            assign q_a       = q2_a;
            assign q_b       = q2_b;
            assign q_valid_a = v2_a;
            assign q_valid_b = v2_b;
        end else begin : g_no_oreg
            assign q_a       = q1_a;
            assign q_b       = q1_b;
            assign q_valid_a = v1_a;
            assign q_valid_b = v1_b;
        end
    endgenerate

endmodule

// File: tb/tb_dpram_param.sv
// ---------------------------------------------------------------------------
// tb_dpram_param
//   Five dpram_param instances share one stimulus stream:
//     0 default (WRITE_FIRST), 1 READ_FIRST, 2 NO_CHANGE,
//     3 CLEAR_EN with ADDR_W=4 / CLEAR_VAL=0xEE, 4 OUT_REG=1.
//   Expected outputs are queued with their due cycle and checked on the
//   falling edge when that cycle arrives.
// ---------------------------------------------------------------------------
module tb_dpram_param;

    localparam int N_INST = 5;
    localparam int F_Q_A = 0, F_QV_A = 1, F_Q_B = 2, F_QV_B = 3, F_COLL = 4, F_BUSY = 5;
    localparam int I_DUT = 0, I_RF = 1, I_NC = 2, I_CLR = 3, I_OR = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, we_a, en_b, we_b;
    logic [10:0] addr_a, addr_b;
    logic [7:0]  data_a, data_b;

    logic [7:0] q_a_o  [N_INST];
    logic [7:0] q_b_o  [N_INST];
    logic       qv_a_o [N_INST];
    logic       qv_b_o [N_INST];
    logic       busy_o [N_INST];
    logic       coll_o [N_INST];

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int          due;
        int          sel;
        logic [35:0] exp;
        string       tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dpram_param #(.WRITE_MODE(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a),
        .q_a(q_a_o[0]), .q_valid_a(qv_a_o[0]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b),
        .q_b(q_b_o[0]), .q_valid_b(qv_b_o[0]),
        .busy(busy_o[0]), .coll(coll_o[0]));

    dpram_param #(.WRITE_MODE(1)) u_rf (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a),
        .q_a(q_a_o[1]), .q_valid_a(qv_a_o[1]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b),
        .q_b(q_b_o[1]), .q_valid_b(qv_b_o[1]),
        .busy(busy_o[1]), .coll(coll_o[1]));

    dpram_param #(.WRITE_MODE(2)) u_nc (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a),
        .q_a(q_a_o[2]), .q_valid_a(qv_a_o[2]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b),
        .q_b(q_b_o[2]), .q_valid_b(qv_b_o[2]),
        .busy(busy_o[2]), .coll(coll_o[2]));

    dpram_param #(.ADDR_W(4), .CLEAR_EN(1), .CLEAR_VAL(8'hEE)) u_clr (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a[3:0]), .data_a(data_a),
        .q_a(q_a_o[3]), .q_valid_a(qv_a_o[3]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b[3:0]), .data_b(data_b),
        .q_b(q_b_o[3]), .q_valid_b(qv_b_o[3]),
        .busy(busy_o[3]), .coll(coll_o[3]));

    dpram_param #(.OUT_REG(1)) u_or (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a),
        .q_a(q_a_o[4]), .q_valid_a(qv_a_o[4]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b),
        .q_b(q_b_o[4]), .q_valid_b(qv_b_o[4]),
        .busy(busy_o[4]), .coll(coll_o[4]));

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [35:0] obs(input int sel);
        int i;
        i = sel / 8;
        case (sel % 8)
            F_Q_A:   return {28'b0, q_a_o[i]};
            F_QV_A:  return {35'b0, qv_a_o[i]};
            F_Q_B:   return {28'b0, q_b_o[i]};
            F_QV_B:  return {35'b0, qv_b_o[i]};
            F_COLL:  return {35'b0, coll_o[i]};
            default: return {35'b0, busy_o[i]};
        endcase
    endfunction

    task automatic expect_at(input int dly, input string tag, input int inst,
                             input int fld, input logic [35:0] exp);
        exp_t e;
        e.due = cyc + dly;
        e.sel = inst * 8 + fld;
        e.exp = exp;
        e.tag = tag;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                chk(sb[i].tag, obs(sb[i].sel), sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit ea, input bit wa, input int aa, input int da,
                         input bit eb, input bit wb, input int ab, input int db);
        en_a = ea; we_a = wa; addr_a = 11'(aa); data_a = 8'(da);
        en_b = eb; we_b = wb; addr_b = 11'(ab); data_b = 8'(db);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int r0;
        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N_INST; i++) begin
            chk("rst_q_a",  obs(i * 8 + F_Q_A),  0);
            chk("rst_qv_a", obs(i * 8 + F_QV_A), 0);
            chk("rst_q_b",  obs(i * 8 + F_Q_B),  0);
            chk("rst_qv_b", obs(i * 8 + F_QV_B), 0);
            chk("rst_coll", obs(i * 8 + F_COLL), 0);
        end
        chk("rst_busy_clr", obs(I_CLR * 8 + F_BUSY), 1);
        chk("rst_busy_dut", obs(I_DUT * 8 + F_BUSY), 0);

        // T5: clear sweep
        step();
        rst_n = 1'b1;
        r0 = cyc;
        for (int k = 0; k < 16; k++) expect_at(k, "busy_hi", I_CLR, F_BUSY, 1);
        expect_at(16, "busy_lo", I_CLR, F_BUSY, 0);
        step();
        step();
        drive(1, 1, 3, 'h12, 0, 0, 0, 0);
        expect_at(1, "busy_ign_v", I_CLR, F_QV_A, 0);
        expect_at(1, "busy_ign_q", I_CLR, F_Q_A, 0);
        step();
        idle();
        while (cyc < r0 + 16) step();
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, i, 0, 0, 0, 0, 0);
            expect_at(1, "clr_q", I_CLR, F_Q_A, 'hEE);
            expect_at(1, "clr_v", I_CLR, F_QV_A, 1);
            step();
        end
        idle();
        step();

        // T1: write on A, read on B
        drive(1, 1, 'h0F6, 'hAA, 0, 0, 0, 0);
        expect_at(1, "t1_wf_q", I_DUT, F_Q_A, 'hAA);
        expect_at(1, "t1_wf_v", I_DUT, F_QV_A, 1);
        expect_at(1, "t1_or_lat", I_OR, F_QV_A, 0);
        expect_at(2, "t1_or_q", I_OR, F_Q_A, 'hAA);
        expect_at(2, "t1_or_v", I_OR, F_QV_A, 1);
        step();
        drive(0, 0, 0, 0, 1, 0, 'h0F6, 0);
        expect_at(1, "t1_q_b", I_DUT, F_Q_B, 'hAA);
        expect_at(1, "t1_qv_b", I_DUT, F_QV_B, 1);
        expect_at(1, "t1_qv_a_idle", I_DUT, F_QV_A, 0);
        step();
        idle();
        step();

        // T2: same-port read-during-write modes
        drive(1, 0, 'h0F6, 0, 0, 0, 0, 0);
        expect_at(1, "t2_nc_rd_q", I_NC, F_Q_A, 'hAA);
        expect_at(1, "t2_nc_rd_v", I_NC, F_QV_A, 1);
        step();
        drive(1, 1, 5, 'h11, 0, 0, 0, 0);
        expect_at(1, "t2_nc_pre_q", I_NC, F_Q_A, 'hAA);
        expect_at(1, "t2_nc_pre_v", I_NC, F_QV_A, 0);
        step();
        drive(1, 1, 5, 'h22, 0, 0, 0, 0);
        expect_at(1, "t2_wf_q", I_DUT, F_Q_A, 'h22);
        expect_at(1, "t2_wf_v", I_DUT, F_QV_A, 1);
        expect_at(1, "t2_rf_q", I_RF, F_Q_A, 'h11);
        expect_at(1, "t2_rf_v", I_RF, F_QV_A, 1);
        expect_at(1, "t2_nc_q", I_NC, F_Q_A, 'hAA);
        expect_at(1, "t2_nc_v", I_NC, F_QV_A, 0);
        step();
        idle();
        step();

        // T3: double write to the same address
        drive(1, 1, 7, 'h33, 1, 1, 7, 'h44);
        expect_at(1, "t3_coll", I_DUT, F_COLL, 1);
        step();
        drive(1, 0, 7, 0, 1, 0, 7, 0);
        expect_at(1, "t3_q_a", I_DUT, F_Q_A, 'h33);
        expect_at(1, "t3_q_b", I_DUT, F_Q_B, 'h33);
        expect_at(1, "t3_qv_b", I_DUT, F_QV_B, 1);
        expect_at(1, "t3_coll_rr", I_DUT, F_COLL, 0);
        step();
        idle();
        step();

        // T4: write/read conflicts in both directions
        drive(1, 1, 9, 'h55, 0, 0, 0, 0);
        step();
        drive(1, 1, 9, 'h66, 1, 0, 9, 0);
        expect_at(1, "t4_old_b", I_DUT, F_Q_B, 'h55);
        expect_at(1, "t4_coll_wr", I_DUT, F_COLL, 1);
        step();
        drive(0, 0, 0, 0, 1, 0, 9, 0);
        expect_at(1, "t4_new_b", I_DUT, F_Q_B, 'h66);
        expect_at(1, "t4_coll_off", I_DUT, F_COLL, 0);
        step();
        drive(1, 0, 9, 0, 1, 1, 9, 'h99);
        expect_at(1, "t4_old_a", I_DUT, F_Q_A, 'h66);
        expect_at(1, "t4_coll_rw", I_DUT, F_COLL, 1);
        step();
        drive(1, 0, 9, 0, 0, 0, 0, 0);
        expect_at(1, "t4_new_a", I_DUT, F_Q_A, 'h99);
        expect_at(1, "t4_coll_off2", I_DUT, F_COLL, 0);
        step();
        idle();
        expect_at(1, "idle_qv_a", I_DUT, F_QV_A, 0);
        expect_at(1, "idle_qv_b", I_DUT, F_QV_B, 0);
        expect_at(1, "idle_q_a_hold", I_DUT, F_Q_A, 'h99);
        step();

        // T6: output register pipeline
        for (int i = 1; i <= 3; i++) begin
            drive(1, 1, i, i, 0, 0, 0, 0);
            step();
        end
        idle();
        step();
        expect_at(1, "t6_gap", I_OR, F_QV_A, 0);
        step();
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, i, 0, 0, 0, 0, 0);
            if (i == 1) expect_at(1, "t6_lat", I_OR, F_QV_A, 0);
            expect_at(2, "t6_q", I_OR, F_Q_A, 36'(i));
            expect_at(2, "t6_v", I_OR, F_QV_A, 1);
            step();
        end
        idle();
        expect_at(2, "t6_tail", I_OR, F_QV_A, 0);
        repeat (3) step();

        // reset while reads are in flight
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 2, 0, 0, 0, 0, 0);
        step();
        chk("t6_pre_rst_v", obs(I_OR * 8 + F_QV_A), 1);
        chk("t6_pre_rst_q", obs(I_OR * 8 + F_Q_A), 'h01);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_v", obs(I_OR * 8 + F_QV_A), 0);
        chk("t6_rst_q", obs(I_OR * 8 + F_Q_A), 0);
        chk("t6_rst_busy", obs(I_CLR * 8 + F_BUSY), 1);
        idle();
        step();
        chk("t6_rst_hold_v", obs(I_OR * 8 + F_QV_A), 0);
        rst_n = 1'b1;
        repeat (3) step();

        chk("sb_drain", 36'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
